// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder: NSTAGE register stages, each resolving BPS skip blocks of
// BLOCK bits. A valid/ready handshake stalls the whole pipe together.
module cskipa_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int BPS   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int SLICE  = (BLOCK * BPS > 0) ? BLOCK * BPS : 1;
    localparam int NSTAGE = WIDTH / SLICE;

    generate
        if (BLOCK < 1 || BPS < 1 || (WIDTH % SLICE) != 0 || NSTAGE < 1) begin : g_bad_param
            $error("cskipa_pipe: WIDTH must be a non-zero multiple of BLOCK*BPS, BLOCK >= 1");
        end
    endgenerate

    logic [NSTAGE-1:0] vld_q;
    logic              cry_d [NSTAGE];
    logic              cry_q [NSTAGE];
    logic [WIDTH-1:0]  a_d   [NSTAGE];
    logic [WIDTH-1:0]  a_q   [NSTAGE];
    logic [WIDTH-1:0]  b_d   [NSTAGE];
    logic [WIDTH-1:0]  b_q   [NSTAGE];
    logic [WIDTH-1:0]  sum_d [NSTAGE];
    logic [WIDTH-1:0]  sum_q [NSTAGE];
    logic              ovf_d;
    logic              ovf_q;

    logic              adv;
    logic [WIDTH-1:0]  a_s;
    logic [WIDTH-1:0]  b_s;
    logic [WIDTH-1:0]  s_s;
    logic              c_s;
    logic              cb_s;
    logic              p_s;
    logic              p_all_s;
    logic              cmsb_s;

    assign o_valid = vld_q[NSTAGE-1];
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;
    assign o_sum   = sum_q[NSTAGE-1];
    assign o_cout  = cry_q[NSTAGE-1];
    assign o_ovf   = ovf_q;

    // Operands and partial sums travel full width; each stage only fills its own slice.
    always_comb begin
        a_s     = '0;
        b_s     = '0;
        s_s     = '0;
        c_s     = 1'b0;
        cb_s    = 1'b0;
        p_s     = 1'b0;
        p_all_s = 1'b0;
        cmsb_s  = 1'b0;
        for (int s = 0; s < NSTAGE; s++) begin
            a_d[s]   = '0;
            b_d[s]   = '0;
            sum_d[s] = '0;
            cry_d[s] = 1'b0;
        end
        for (int s = 0; s < NSTAGE; s++) begin
            int ps;
            ps = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                a_s = i_add_term1;
                b_s = i_add_term2;
                s_s = '0;
                c_s = i_cin;
            end else begin
                a_s = a_q[ps];
                b_s = b_q[ps];
                s_s = sum_q[ps];
                c_s = cry_q[ps];
            end
            for (int k = 0; k < BPS; k++) begin
                cb_s    = c_s;
                p_all_s = 1'b1;
                for (int j = 0; j < BLOCK; j++) begin
                    int idx;
                    idx = s * SLICE + k * BLOCK + j;
                    p_s = a_s[idx] ^ b_s[idx];
                    s_s[idx] = p_s ^ cb_s;
                    if (idx == WIDTH - 1) begin
                        cmsb_s = cb_s;
                    end
                    cb_s    = (a_s[idx] & b_s[idx]) | (p_s & cb_s);
                    p_all_s = p_all_s & p_s;
                end
                // A fully propagating block passes its carry-in straight through.
                c_s = p_all_s ? c_s : cb_s;
            end
            a_d[s]   = a_s;
            b_d[s]   = b_s;
            sum_d[s] = s_s;
            cry_d[s] = c_s;
        end
        ovf_d = cmsb_s ^ cry_d[NSTAGE-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int s = 0; s < NSTAGE; s++) begin
                cry_q[s] <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else if (adv) begin
            ovf_q <= ovf_d;
            for (int s = 0; s < NSTAGE; s++) begin
                vld_q[s] <= (s == 0) ? i_valid : vld_q[(s > 0) ? s - 1 : 0];
                cry_q[s] <= cry_d[s];
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                sum_q[s] <= sum_d[s];
            end
        end
    end

endmodule

// File: tb/tb_cskipa_pipe.sv
// Bench for cskipa_pipe: directed corner cases plus random streams, scored against an
// arithmetic reference held in an in-order queue.
module tb_cskipa_pipe;

    localparam int W   = 32;
    localparam int NST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [W-1:0]  ta = '0;
    logic [W-1:0]  tbv = '0;
    logic          tc = 1'b0;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic [W-1:0]  sum_out;
    logic          cout_out;
    logic          ovf_out;

    int            n_vec = 0;
    int            n_err = 0;
    logic          chk_lat = 1'b0;
    logic [NST-1:0] hist = '0;
    logic          stall_prev = 1'b0;
    logic [W+1:0]  held = '0;
    logic [W+1:0]  exp_q [$];

    cskipa_pipe #(.WIDTH(W), .BLOCK(4), .BPS(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid_in),
        .o_ready     (ready_out),
        .i_add_term1 (ta),
        .i_add_term2 (tbv),
        .i_cin       (tc),
        .o_valid     (valid_out),
        .i_ready     (ready_in),
        .o_sum       (sum_out),
        .o_cout      (cout_out),
        .o_ovf       (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, cout, sum} straight from integer addition.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        logic [W:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {v, s};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hist       = '0;
            stall_prev = 1'b0;
        end else begin
            logic [W+1:0] e;
            logic         xfer;
            if (chk_lat) check("latency_valid", valid_out, hist[NST-1]);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", valid_out, 0);
                end else begin
                    e = exp_q[0];
                    check("sum", sum_out, e[W-1:0]);
                    check("cout", cout_out, e[W]);
                    check("ovf", ovf_out, e[W+1]);
                    if (ready_in) void'(exp_q.pop_front());
                end
                if (stall_prev) check("hold", {ovf_out, cout_out, sum_out}, held);
            end
            stall_prev = valid_out && !ready_in;
            held       = {ovf_out, cout_out, sum_out};
            xfer       = valid_in && ready_out;
            if (xfer) exp_q.push_back(model(ta, tbv, tc));
            hist = {hist[NST-2:0], xfer};
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t;
        valid_in = 1'b1;
        ta  = a;
        tbv = b;
        tc  = c;
        t = 0;
        @(negedge clk);
        while (!ready_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready_out) check("send_timeout", ready_out, 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic       acc;
        logic [5:0] pat;
        int         t;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", cout_out, 0);
        check("rst_ovf", ovf_out, 0);
        check("rst_ready", ready_out, 1);
        rst_n = 1'b1;
        chk_lat = 1'b1;
        idle(2);

        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        idle(6);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
        idle(6);

        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle(6);

        for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        chk_lat  = 1'b0;
        ready_in = 1'b0;
        valid_in = 1'b1;
        ta  = $urandom;
        tbv = $urandom;
        tc  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", ready_out, 0);
            check("bp_valid", valid_out, 1);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        send(ta, tbv, tc);
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle(8);
        chk_lat = 1'b1;

        pat = 6'b100101;
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) send(W'(i), W'(i), 1'b0);
            else idle(1);
        end
        idle(6);

        chk_lat = 1'b0;
        acc = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!valid_in || acc) begin
                valid_in = 1'($urandom_range(0, 1));
                ta  = $urandom;
                tbv = $urandom;
                tc  = 1'($urandom_range(0, 1));
            end
            ready_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = valid_in && ready_out;
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        idle(10);
        chk_lat = 1'b1;

        for (int i = 0; i < 5; i++) send(W'(32'h1000 + i), W'(32'h0F0F_0F0F), 1'b1);
        check("pre_rst_valid", valid_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid_out, 0);
        check("arst_sum", sum_out, 0);
        check("arst_cout", cout_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        send(32'h1, 32'h2, 1'b0);
        idle(6);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/cskipa_pipe.md
Name: cskipa_pipe

Overview:
- Parametrised, pipelined carry-skip adder; successor to the fixed 12-bit, 4-bit-block combinational carry-skip adder.
- Operand width, skip-block size and blocks per pipeline stage are parameters.
- Adds a carry-in, a signed-overflow flag and a valid/ready handshake with full-pipeline backpressure.
- Sits between operand-issue logic and the result writeback path of the adder-characterisation datapath.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK*BPS.
- BLOCK, 4, bits per carry-skip block (ripple inside the block, skip mux on block propagate).
- BPS, 2, skip blocks evaluated per pipeline stage; NSTAGE = WIDTH/(BLOCK*BPS) (default 4).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block accepts operands this cycle.
- i_add_term1  input  WIDTH  operand A.
- i_add_term2  input  WIDTH  operand B.
- i_cin  input  1  carry-in to bit 0.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  WIDTH  A+B+cin, low WIDTH bits.
- o_cout  output  1  carry out of the MSB.
- o_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, o_valid = 0, o_sum = 0, o_cout = 0, o_ovf = 0, all carry/skew registers = 0. o_ready = 1 while out of reset.
- Global advance: en = !o_valid || i_ready. o_ready = en, combinational.
- Transfer in when i_valid && o_ready. Transfer out when o_valid && i_ready.
- Structure: stage s (0..NSTAGE-1) computes sum bits [(s+1)*BLOCK*BPS-1 : s*BLOCK*BPS] from:
  - the carry registered by stage s-1 (i_cin for stage 0);
  - operand slices delayed s cycles through skew registers.
- Within a stage, each block ripples, then cin_next = (&P_block) ? cin_block : ripple_cout.
- Upper operand slices are carried forward; computed sum slices are carried forward and aligned.
- Latency: exactly NSTAGE cycles from input transfer to o_valid with no stall (4 at default). Throughput: one result per cycle.
- Stall: when en = 0, every stage register (valid, data, carry) holds. No result is dropped or duplicated. o_sum/o_cout/o_ovf stay stable while o_valid && !i_ready.
- Bubbles: when en = 1 and no input transfer, a valid = 0 slot enters stage 0.
  - Data registers of invalid slots may update; outputs are don't-care when o_valid = 0.
  - Stage valid bits shift regardless, so bubbles collapse only at the output.
- Arithmetic: unsigned modulo 2^WIDTH. o_cout = bit WIDTH of A+B+cin. o_ovf = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
- Skip path and ripple path must agree for every input; full propagate (A^B all ones) uses the skip path end to end.
- Simultaneous in/out transfer with a full pipeline is legal; occupancy stays at NSTAGE.
- Reset mid-operation: all in-flight results are discarded; no o_valid after reset release until a new input has traversed NSTAGE cycles.
- Elaboration error if WIDTH % (BLOCK*BPS) != 0 or BLOCK < 1.

Test Plan (defaults WIDTH=32, BLOCK=4, BPS=2, i_ready=1 unless stated):
- Full-propagate carry chain: A=0xFFFFFFFF, B=0x00000000, cin=1, then B=0x00000001, cin=0 on the next cycle -> both results sum=0x00000000, cout=1, ovf=0, on cycles 4 and 5 after issue.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. A=0x80000000, B=0x80000000 -> sum=0, cout=1, ovf=1.
- Back-to-back stream: 100 random operand pairs with i_valid held high -> 100 results in order, each equal to the reference A+B+cin, one per cycle, first at latency 4.
- Backpressure: fill the pipe, drop i_ready for 3 cycles -> o_ready=0 and o_valid=1 with o_sum held constant; on release the remaining results emerge in order with none lost.
- Bubbles: i_valid pattern 1,0,1,0,0,1 with A=i, B=i -> o_valid replicates the pattern 4 cycles later with sums 0, 4, 10.
- Async reset with 3 results in flight: assert i_rst_n=0 mid-cycle -> o_valid=0 and o_sum=0 immediately; no stale results after release; then 0x1+0x2 -> sum=0x3 after 4 cycles.
